// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle FSM and the RV32I datapath.
// The FSM side drives every mux select and enable; the datapath returns IR fields and zero.
interface multicycle_control_fsm_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       zero;
    logic       PCWrite;
    logic       PCBackWrite;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] OrigAULA;
    logic [1:0] OrigBULA;
    logic [1:0] Mem2Reg;
    logic       PCSource;
    logic [1:0] ALUOp;
    logic       illegal;
    logic [3:0] estado;

    modport master (
        input  opcode, funct3, zero,
        output PCWrite, PCBackWrite, IorD, MemRead, MemWrite,
        output IRWrite, RegWrite, OrigAULA, OrigBULA, Mem2Reg,
        output PCSource, ALUOp, illegal, estado
    );

    modport slave (
        output opcode, funct3, zero,
        input  PCWrite, PCBackWrite, IorD, MemRead, MemWrite,
        input  IRWrite, RegWrite, OrigAULA, OrigBULA, Mem2Reg,
        input  PCSource, ALUOp, illegal, estado
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the RV32I multicycle datapath with a unified memory.
// Memory states hold for MEM_LATENCY cycles; illegal opcodes park in a sticky HALT.
module multicycle_control_fsm #(
    parameter int MEM_LATENCY = 2,
    parameter int CNT_W       = 3
) (
    input logic                      clockCPU,
    input logic                      reset,
    multicycle_control_fsm_if.master bus
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        EXEC_R  = 4'd2,
        EXEC_I  = 4'd3,
        ADDR    = 4'd4,
        MEM_RD  = 4'd5,
        WB_LOAD = 4'd6,
        MEM_WR  = 4'd7,
        BRANCH  = 4'd8,
        JAL     = 4'd9,
        JALR    = 4'd10,
        LUI     = 4'd11,
        ALU_WB  = 4'd12,
        HALT    = 4'd15
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last;
    logic             wait_st;

    logic op_r, op_i, op_ld, op_st, op_br, op_jal, op_jalr, op_lui;

    assign op_r    = bus.opcode == 7'b0110011;
    assign op_i    = bus.opcode == 7'b0010011;
    assign op_ld   = bus.opcode == 7'b0000011;
    assign op_st   = bus.opcode == 7'b0100011;
    assign op_br   = bus.opcode == 7'b1100011;
    assign op_jal  = bus.opcode == 7'b1101111;
    assign op_jalr = bus.opcode == 7'b1100111;
    assign op_lui  = bus.opcode == 7'b0110111;

    assign last    = cnt_q == CNT_LAST;
    assign wait_st = (state_q == FETCH) || (state_q == MEM_RD) ||
                     (state_q == MEM_WR);

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   if (last) state_d = DECODE;
            DECODE: begin
                unique case (1'b1)
                    op_r:    state_d = EXEC_R;
                    op_i:    state_d = EXEC_I;
                    op_ld:   state_d = ADDR;
                    op_st:   state_d = ADDR;
                    op_br:   state_d = BRANCH;
                    op_jal:  state_d = JAL;
                    op_jalr: state_d = JALR;
                    op_lui:  state_d = LUI;
                    default: state_d = HALT;
                endcase
            end
            EXEC_R:  state_d = ALU_WB;
            EXEC_I:  state_d = ALU_WB;
            ALU_WB:  state_d = FETCH;
            ADDR:    state_d = op_ld ? MEM_RD : MEM_WR;
            MEM_RD:  if (last) state_d = WB_LOAD;
            WB_LOAD: state_d = FETCH;
            MEM_WR:  if (last) state_d = FETCH;
            BRANCH:  state_d = FETCH;
            JAL:     state_d = FETCH;
            JALR:    state_d = FETCH;
            LUI:     state_d = ALU_WB;
            default: state_d = HALT;
        endcase
    end

    // Any state change clears the counter, so each memory state starts at 0.
    always_comb begin
        cnt_d = '0;
        if (wait_st && state_d == state_q) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clockCPU or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.estado = state_q;

    always_comb begin
        bus.PCWrite     = 1'b0;
        bus.PCBackWrite = 1'b0;
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.OrigAULA    = 2'd0;
        bus.OrigBULA    = 2'd0;
        bus.Mem2Reg     = 2'd0;
        bus.PCSource    = 1'b0;
        bus.ALUOp       = 2'd0;
        bus.illegal     = 1'b0;
        case (state_q)
            FETCH: begin
                bus.MemRead  = 1'b1;
                bus.OrigBULA = 2'd1;
                if (last) begin
                    bus.IRWrite     = 1'b1;
                    bus.PCBackWrite = 1'b1;
                    bus.PCWrite     = 1'b1;
                end
            end
            DECODE: begin
                bus.OrigAULA = 2'd2;
                bus.OrigBULA = 2'd2;
            end
            EXEC_R: begin
                bus.OrigAULA = 2'd1;
                bus.ALUOp    = 2'd2;
            end
            EXEC_I: begin
                bus.OrigAULA = 2'd1;
                bus.OrigBULA = 2'd2;
                bus.ALUOp    = 2'd2;
            end
            ALU_WB:  bus.RegWrite = 1'b1;
            ADDR: begin
                bus.OrigAULA = 2'd1;
                bus.OrigBULA = 2'd2;
            end
            MEM_RD: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
            end
            WB_LOAD: begin
                bus.RegWrite = 1'b1;
                bus.Mem2Reg  = 2'd1;
            end
            MEM_WR: begin
                bus.MemWrite = 1'b1;
                bus.IorD     = 1'b1;
            end
            BRANCH: begin
                bus.OrigAULA = 2'd1;
                bus.ALUOp    = 2'd1;
                bus.PCSource = 1'b1;
                case (bus.funct3)
                    3'b000:  bus.PCWrite = bus.zero;
                    3'b001:  bus.PCWrite = ~bus.zero;
                    default: bus.PCWrite = 1'b0;
                endcase
            end
            JAL: begin
                bus.RegWrite = 1'b1;
                bus.Mem2Reg  = 2'd2;
                bus.PCWrite  = 1'b1;
                bus.PCSource = 1'b1;
            end
            JALR: begin
                bus.OrigAULA = 2'd1;
                bus.OrigBULA = 2'd2;
                bus.RegWrite = 1'b1;
                bus.Mem2Reg  = 2'd2;
                bus.PCWrite  = 1'b1;
            end
            LUI: begin
                bus.OrigAULA = 2'd3;
                bus.OrigBULA = 2'd2;
            end
            HALT:    bus.illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm at MEM_LATENCY 2 and 3.
// Expected state sequences and strobes are written out by hand.
module tb_multicycle_control_fsm;

    logic clk;
    logic rst2;
    logic rst3;
    int   nvec;
    int   nerr;

    multicycle_control_fsm_if if2 ();
    multicycle_control_fsm_if if3 ();

    multicycle_control_fsm #(.MEM_LATENCY(2), .CNT_W(3)) dut2 (
        .clockCPU (clk),
        .reset    (rst2),
        .bus      (if2)
    );

    multicycle_control_fsm #(.MEM_LATENCY(3), .CNT_W(3)) dut3 (
        .clockCPU (clk),
        .reset    (rst3),
        .bus      (if3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        nvec++;
        if (obs !== exp_v) begin
            nerr++;
            $display("FAIL %s: got %0h required %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Checks estado over n cycles; seq lists states left to right, one nibble each.
    task automatic go(input string tag, input int n, input logic [63:0] seq);
        for (int i = 0; i < n; i++) begin
            if (i > 0) tick();
            chk($sformatf("%s_st%0d", tag, i), 32'(if2.estado),
                32'(seq[4*(n-1-i) +: 4]));
        end
    endtask

    task automatic br(input string tag, input logic [2:0] f3,
                      input logic pcw_z1, input logic pcw_z0);
        if2.opcode = 7'b1100011;
        if2.funct3 = f3;
        go(tag, 4, 64'h0018);
        if2.zero = 1'b1;
        #1;
        chk({tag, "_pcw_z1"}, 32'(if2.PCWrite), 32'(pcw_z1));
        chk({tag, "_pcsrc"}, 32'(if2.PCSource), 32'd1);
        if2.zero = 1'b0;
        #1;
        chk({tag, "_pcw_z0"}, 32'(if2.PCWrite), 32'(pcw_z0));
        tick();
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        rst2 = 1'b0;
        rst3 = 1'b0;
        if2.opcode = 7'b0110011;
        if2.funct3 = 3'b000;
        if2.zero   = 1'b0;
        if3.opcode = 7'b0100011;
        if3.funct3 = 3'b000;
        if3.zero   = 1'b0;

        @(negedge clk);
        @(negedge clk);
        chk("rst_estado", 32'(if2.estado), 32'd0);
        chk("rst_memread", 32'(if2.MemRead), 32'd1);
        chk("rst_irwrite", 32'(if2.IRWrite), 32'd0);
        chk("rst_pcwrite", 32'(if2.PCWrite), 32'd0);
        chk("rst_illegal", 32'(if2.illegal), 32'd0);
        rst2 = 1'b1;
        #1;

        // R-type: 0,0,1,2,12,0
        for (int i = 0; i < 6; i++) begin
            logic [23:0] seq;
            seq = 24'h0012C0;
            if (i > 0) tick();
            chk($sformatf("r_st%0d", i), 32'(if2.estado),
                32'(seq[4*(5-i) +: 4]));
            chk($sformatf("r_irw%0d", i), 32'(if2.IRWrite), 32'(i == 1));
            chk($sformatf("r_pcw%0d", i), 32'(if2.PCWrite), 32'(i == 1));
            chk($sformatf("r_rw%0d", i), 32'(if2.RegWrite), 32'(i == 4));
        end

        // Load: 0,0,1,4,5,5,6,0
        if2.opcode = 7'b0000011;
        go("ld", 4, 64'h0014);
        chk("ld_addr_memrd", 32'(if2.MemRead), 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk($sformatf("ld_mr_st%0d", i), 32'(if2.estado), 32'd5);
            chk($sformatf("ld_mr_rd%0d", i), 32'(if2.MemRead), 32'd1);
            chk($sformatf("ld_mr_iord%0d", i), 32'(if2.IorD), 32'd1);
            chk($sformatf("ld_mr_rw%0d", i), 32'(if2.RegWrite), 32'd0);
        end
        tick();
        chk("ld_wb_st", 32'(if2.estado), 32'd6);
        chk("ld_wb_rw", 32'(if2.RegWrite), 32'd1);
        chk("ld_wb_m2r", 32'(if2.Mem2Reg), 32'd1);
        chk("ld_wb_memrd", 32'(if2.MemRead), 32'd0);
        tick();
        chk("ld_end_st", 32'(if2.estado), 32'd0);

        br("beq", 3'b000, 1'b1, 1'b0);
        br("bne", 3'b001, 1'b0, 1'b1);
        br("blt", 3'b100, 1'b0, 1'b0);

        if2.opcode = 7'b1101111;
        go("jal", 3, 64'h001);
        chk("dec_a", 32'(if2.OrigAULA), 32'd2);
        chk("dec_b", 32'(if2.OrigBULA), 32'd2);
        tick();
        chk("jal_st", 32'(if2.estado), 32'd9);
        chk("jal_rw", 32'(if2.RegWrite), 32'd1);
        chk("jal_m2r", 32'(if2.Mem2Reg), 32'd2);
        chk("jal_pcw", 32'(if2.PCWrite), 32'd1);
        chk("jal_pcsrc", 32'(if2.PCSource), 32'd1);
        tick();

        if2.opcode = 7'b1100111;
        go("jalr", 4, 64'h001A);
        chk("jalr_pcw", 32'(if2.PCWrite), 32'd1);
        chk("jalr_pcsrc", 32'(if2.PCSource), 32'd0);
        chk("jalr_b", 32'(if2.OrigBULA), 32'd2);
        chk("jalr_m2r", 32'(if2.Mem2Reg), 32'd2);
        tick();

        if2.opcode = 7'b0110111;
        go("lui", 4, 64'h001B);
        chk("lui_a", 32'(if2.OrigAULA), 32'd3);
        chk("lui_rw", 32'(if2.RegWrite), 32'd0);
        tick();
        chk("lui_wb_st", 32'(if2.estado), 32'd12);
        chk("lui_wb_rw", 32'(if2.RegWrite), 32'd1);
        tick();

        if2.opcode = 7'b0010011;
        go("ei", 4, 64'h0013);
        chk("ei_aluop", 32'(if2.ALUOp), 32'd2);
        chk("ei_b", 32'(if2.OrigBULA), 32'd2);
        tick();
        chk("ei_wb_st", 32'(if2.estado), 32'd12);
        tick();

        // Illegal opcode parks in HALT until reset.
        if2.opcode = 7'b0000000;
        go("ill", 4, 64'h001F);
        chk("ill_flag", 32'(if2.illegal), 32'd1);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk($sformatf("halt_st%0d", i), 32'(if2.estado), 32'd15);
        end
        chk("halt_ill", 32'(if2.illegal), 32'd1);
        chk("halt_memrd", 32'(if2.MemRead), 32'd0);
        @(negedge clk);
        rst2 = 1'b0;
        #1;
        chk("halt_rst_st", 32'(if2.estado), 32'd0);
        chk("halt_rst_ill", 32'(if2.illegal), 32'd0);
        chk("halt_rst_mr", 32'(if2.MemRead), 32'd1);
        @(negedge clk);
        rst2 = 1'b1;
        #1;

        // Reset during first MEM_RD cycle.
        if2.opcode = 7'b0000011;
        go("rmr", 5, 64'h00145);
        rst2 = 1'b0;
        #1;
        chk("rmr_st", 32'(if2.estado), 32'd0);
        chk("rmr_mw", 32'(if2.MemWrite), 32'd0);
        chk("rmr_rw", 32'(if2.RegWrite), 32'd0);
        chk("rmr_iord", 32'(if2.IorD), 32'd0);
        @(negedge clk);
        rst2 = 1'b1;
        #1;
        chk("rmr_f0_st", 32'(if2.estado), 32'd0);
        chk("rmr_f0_irw", 32'(if2.IRWrite), 32'd0);
        tick();
        chk("rmr_f1_st", 32'(if2.estado), 32'd0);
        chk("rmr_f1_irw", 32'(if2.IRWrite), 32'd1);
        tick();
        chk("rmr_dec", 32'(if2.estado), 32'd1);

        // Store at latency 3: 0,0,0,1,4,7,7,7,0
        @(negedge clk);
        rst3 = 1'b1;
        #1;
        for (int i = 0; i < 9; i++) begin
            logic [35:0] seq;
            seq = 36'h000147770;
            if (i > 0) tick();
            chk($sformatf("st_st%0d", i), 32'(if3.estado),
                32'(seq[4*(8-i) +: 4]));
            chk($sformatf("st_mw%0d", i), 32'(if3.MemWrite),
                32'(i >= 5 && i <= 7));
            chk($sformatf("st_irw%0d", i), 32'(if3.IRWrite), 32'(i == 2));
            chk($sformatf("st_rw%0d", i), 32'(if3.RegWrite), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Parametrised main control FSM for the RV32I multicycle datapath, with one unified instruction/data memory.
- Generalises the fixed-timing controller: the memory latency is a parameter, with an internal wait counter for fetch, load and store.
- Branch condition (BEQ/BNE) is resolved internally, and illegal opcodes trap to a sticky halt.
- Drives every datapath mux/enable; exports `estado` for the board debug display.

Parameters:
- MEM_LATENCY, 2, cycles the unified memory needs per access (legal 1..8); each memory state is held this many cycles.
- CNT_W, 3, width of the wait counter; must satisfy 2^CNT_W > MEM_LATENCY.

Ports:
- clockCPU  input  1  CPU clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- opcode  input  7  IR[6:0].
- funct3  input  3  IR[14:12].
- zero  input  1  ALU zero flag (combinational, current cycle).
- PCWrite  output  1  load PC from the PCSource mux.
- PCBackWrite  output  1  latch the current PC into PCBack (address of the executing instruction).
- IorD  output  1  memory address: 0 = PC, 1 = ALUOut.
- MemRead  output  1  memory read enable.
- MemWrite  output  1  memory write enable.
- IRWrite  output  1  load IR from memory q.
- RegWrite  output  1  register file write.
- OrigAULA  output  2  ALU A: 0 = PC, 1 = regA, 2 = PCBack, 3 = zero.
- OrigBULA  output  2  ALU B: 0 = regB, 1 = const 4, 2 = imm.
- Mem2Reg  output  2  write-back source: 0 = ALUOut, 1 = MDR, 2 = PC.
- PCSource  output  1  0 = ALU result (combinational), 1 = ALUOut.
- ALUOp  output  2  0 = add, 1 = sub/compare, 2 = funct decode (R/I).
- illegal  output  1  high while in HALT.
- estado  output  4  current state encoding.

Behaviour:
- State encoding:
  - FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, ADDR=4, MEM_RD=5, WB_LOAD=6, MEM_WR=7, BRANCH=8, JAL=9, JALR=10, LUI=11, ALU_WB=12, HALT=15.
  - 13 and 14 are unused; if entered, they go to HALT.
- Wait counter `cnt`:
  - Cleared on entering FETCH, MEM_RD and MEM_WR.
  - Increments each cycle while in those states.
  - "last" = (cnt == MEM_LATENCY-1).
- Outputs are Moore (decoded from state and last), except PCWrite in BRANCH, which is combinational on `zero`. Any signal not listed for a state is 0.
- FETCH:
  - Every cycle: MemRead=1, IorD=0, OrigAULA=0, OrigBULA=1, ALUOp=0.
  - On last: IRWrite=1, PCBackWrite=1, PCWrite=1, PCSource=0 (PC <= PC+4), then go to DECODE.
  - Otherwise stay.
- DECODE:
  - OrigAULA=2, OrigBULA=2, ALUOp=0; ALUOut <= PCBack+imm (branch/JAL target).
  - Next state by opcode: 0110011→EXEC_R, 0010011→EXEC_I, 0000011/0100011→ADDR, 1100011→BRANCH, 1101111→JAL, 1100111→JALR, 0110111→LUI, anything else→HALT.
- EXEC_R: OrigAULA=1, OrigBULA=0, ALUOp=2 → ALU_WB.
- EXEC_I: OrigAULA=1, OrigBULA=2, ALUOp=2 → ALU_WB.
- ALU_WB: RegWrite=1, Mem2Reg=0 → FETCH.
- ADDR: OrigAULA=1, OrigBULA=2, ALUOp=0 → MEM_RD if opcode=0000011, else MEM_WR.
- MEM_RD: MemRead=1, IorD=1 for MEM_LATENCY cycles → WB_LOAD.
- WB_LOAD: RegWrite=1, Mem2Reg=1 → FETCH.
- MEM_WR: MemWrite=1, IorD=1 for MEM_LATENCY cycles → FETCH.
- BRANCH:
  - OrigAULA=1, OrigBULA=0, ALUOp=1, PCSource=1.
  - PCWrite = (funct3==000) ? zero : (funct3==001) ? ~zero : 0.
  - Other funct3 values are no-ops. → FETCH.
- JAL: RegWrite=1, Mem2Reg=2, PCWrite=1, PCSource=1 → FETCH.
- JALR: OrigAULA=1, OrigBULA=2, ALUOp=0, RegWrite=1, Mem2Reg=2, PCWrite=1, PCSource=0 → FETCH. The datapath clears bit 0 of the target.
- LUI: OrigAULA=3, OrigBULA=2, ALUOp=0 → ALU_WB.
- HALT: all enables 0, illegal=1; sticky until reset.
- Cycle counts (L = MEM_LATENCY):
  - R / I-ALU / LUI: L+3.
  - Load: 2L+3.
  - Store: 2L+2.
  - Branch / JAL / JALR: L+2.
- Reset:
  - reset=0 asynchronously forces state=FETCH and cnt=0, from any state, including mid-access or HALT.
  - While reset is low, outputs equal the FETCH (non-last) decode: MemRead=1, every write enable 0, estado=0.
  - The first rising edge after release begins counting fetch cycle 0.

Test Plan:
- L=2, R-type (0110011) after reset release → estado sequence 0,0,1,2,12,0; IRWrite/PCWrite high only on the 2nd FETCH cycle; RegWrite high only in state 12.
- L=2, load (0000011) → 0,0,1,4,5,5,6,0; MemRead=1 & IorD=1 for exactly 2 cycles; Mem2Reg=1 with RegWrite in state 6.
- L=3, store (0100011) → FETCH held 3 cycles, MEM_WR held 3 cycles with MemWrite=1; total 8 cycles; RegWrite never asserted.
- BEQ with zero=1 → PCWrite=1, PCSource=1 in state 8. BNE with zero=1 → PCWrite=0. BNE with zero=0 → PCWrite=1.
- opcode 0000000 → DECODE→HALT (estado=15), illegal=1 for 20+ cycles; reset low for 1 cycle → estado=0, illegal=0.
- L=2, reset asserted during the 1st MEM_RD cycle → immediate estado=0 and MemWrite/RegWrite=0; after release, a normal 2-cycle fetch occurs.
